alu_cmd_rx: RTL and testbench
=============================

ALU_CMD_RX -- requirements
Module: alu_cmd_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated.
REQ-003 Parameter TIMEOUT_BITS, default 32, maximum idle gap between bytes of one frame, in bit periods.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx  in  1  UART serial input, 8N1, idle high, asynchronous to clk.
REQ-007 reg_a  out  8  operand A.
REQ-008 reg_b  out  8  operand B.
REQ-009 sel  out  3  ALU operation select.
REQ-010 shift  out  4  shift amount.
REQ-011 load  out  1  one-cycle strobe; operand outputs were updated this cycle.
REQ-012 frame_err  out  1  one-cycle strobe; a frame or byte was rejected.
REQ-013 busy  out  1  high while a frame is partially received.

Function
REQ-014 rx SHALL pass through a 2-FF synchronizer; all logic SHALL use only the synchronized value.
REQ-015 Byte RX: a falling edge in idle SHALL start a half-bit wait; rx still low then confirms the start bit, otherwise the edge is discarded as a glitch and the block returns to idle without an error.
REQ-016 Byte RX: the block SHALL sample 8 data bits LSB first, then the stop bit, each CLKS_PER_BIT clocks after the previous sample.
REQ-017 Byte RX: stop bit = 0 SHALL discard the byte, pulse frame_err, and return the parser to P_HDR.
REQ-018 Frame format: 0xA5 header, A, B, CTRL, CHK; CTRL[2:0]=sel, CTRL[6:3]=shift, CTRL[7]=0; CHK = A ^ B ^ CTRL.
REQ-019 Parser FSM states: P_HDR, P_A, P_B, P_CTRL, P_CHK; each received byte advances one state.
REQ-020 P_HDR: any byte other than 0xA5 SHALL be ignored silently, with no error pulse.
REQ-021 P_CHK: a correct CHK with CTRL[7]=0 SHALL update reg_a, reg_b, sel and shift together and pulse load, both in the clock cycle after the CHK stop-bit sample.
REQ-022 P_CHK: a wrong CHK or CTRL[7]=1 SHALL leave all outputs unchanged, pulse frame_err, and return to P_HDR.
REQ-023 Timeout: with parser state not P_HDR, a gap longer than TIMEOUT_BITS*CLKS_PER_BIT clocks since the last stop bit SHALL return the parser to P_HDR and pulse frame_err.
REQ-024 busy SHALL be 1 whenever the parser state is not P_HDR or a byte is being received.
REQ-025 load and frame_err SHALL never both be high in the same cycle.
REQ-026 After a completed or aborted frame, the block SHALL accept a new start bit from the next falling edge, with no dead time.
REQ-027 Operand outputs SHALL hold their values between valid frames.

Reset
REQ-028 While rst is high, the following SHALL hold: reg_a=0, reg_b=0, sel=0, shift=0, load=0, frame_err=0, busy=0, parser state P_HDR, byte RX idle, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first byte accepted after release is parsed as a header candidate.

Structure
REQ-030 Shared package alu_pkg SHALL hold: the header constant 0xA5, the CTRL field positions and widths, and the parser state enum.
REQ-031 The byte receiver SHALL be a sub-module, uart_rx_byte, with outputs data[7:0], valid and stop_err; alu_cmd_rx SHALL contain the synchronizer, parser and timeout counter.

Verification (CLK_HZ=1_000_000, BAUD=100_000, 10 clocks/bit)
REQ-032 Frame A5 12 34 1B 3D -> load pulses once; reg_a=0x12, reg_b=0x34, sel=3, shift=3.
REQ-033 Frame A5 12 34 1B 00 -> frame_err pulses once; outputs keep their previous values; load stays low.
REQ-034 Bytes 00 FF A5 01 02 05 06 -> the junk bytes are ignored; load pulses; reg_a=1, reg_b=2, sel=5, shift=0.
REQ-035 A5 01, then 400 idle clocks, then A5 0A 0B 01 00 -> one frame_err at timeout; then load pulses with reg_a=0x0A, reg_b=0x0B, sel=1, shift=0.
REQ-036 A 3-clock low glitch on rx in idle -> no byte, no error; a byte with stop bit 0 -> frame_err; CTRL=0x80 with matching CHK -> frame_err.
REQ-037 rst pulsed during byte B of a frame -> all outputs 0; a following full valid frame loads correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the serial ALU command receiver.
// Frame: HDR, A, B, CTRL, CHK with CHK = A ^ B ^ CTRL.
package alu_pkg;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int CTRL_SEL_LSB = 0;
  localparam int CTRL_SEL_W = 3;
  localparam int CTRL_SHIFT_LSB = 3;
  localparam int CTRL_SHIFT_W = 4;
  localparam int CTRL_RSV_BIT = 7;

  typedef enum logic [2:0] {
    P_HDR,
    P_A,
    P_B,
    P_CTRL,
    P_CHK
  } p_state_t;

  function automatic logic [7:0] frame_chk(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return a ^ b ^ c;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver on an already-synchronized serial line.
// valid/stop_err are asserted in the cycle whose edge samples the stop bit.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       stop_err,
  output logic       active
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          prev_q;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    valid    = 1'b0;
    stop_err = 1'b0;
    case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx) st_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = S_STOP;
        end
      end
      default: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          valid    = rx;
          stop_err = !rx;
          st_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      prev_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      prev_q <= rx;
    end
  end

  assign data   = sh_q;
  assign active = (st_q != S_IDLE);
endmodule

// File: rtl/alu_cmd_rx.sv
// UART command receiver: synchronizer, frame parser and inter-byte
// timeout feeding operand registers of an ALU.
module alu_cmd_rx
  import alu_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic [2:0] sel,
  output logic [3:0] shift,
  output logic       load,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);

  logic       sync1_q, sync2_q;
  logic [7:0] byte_data;
  logic       byte_vld, byte_err, rx_active;

  p_state_t   p_q, p_d;
  logic [7:0] ta_q, ta_d, tb_q, tb_d, tc_q, tc_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] sh_q, sh_d;
  logic       load_q, load_d, err_q, err_d;
  logic [31:0] tmo_q, tmo_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (sync2_q),
    .data     (byte_data),
    .valid    (byte_vld),
    .stop_err (byte_err),
    .active   (rx_active)
  );

  always_comb begin
    p_d    = p_q;
    ta_d   = ta_q;
    tb_d   = tb_q;
    tc_d   = tc_q;
    a_d    = a_q;
    b_d    = b_q;
    sel_d  = sel_q;
    sh_d   = sh_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    // Gap is measured only while the line is idle inside a frame.
    tmo_d  = (p_q == P_HDR || rx_active) ? '0 : tmo_q + 1'b1;
    if (byte_err) begin
      err_d = 1'b1;
      p_d   = P_HDR;
    end else if (byte_vld) begin
      unique case (p_q)
        P_HDR:  if (byte_data == HDR_BYTE) p_d = P_A;
        P_A:    begin ta_d = byte_data; p_d = P_B; end
        P_B:    begin tb_d = byte_data; p_d = P_CTRL; end
        P_CTRL: begin tc_d = byte_data; p_d = P_CHK; end
        P_CHK: begin
          p_d = P_HDR;
          if (byte_data == frame_chk(ta_q, tb_q, tc_q) &&
              !tc_q[CTRL_RSV_BIT]) begin
            a_d    = ta_q;
            b_d    = tb_q;
            sel_d  = tc_q[CTRL_SEL_LSB +: CTRL_SEL_W];
            sh_d   = tc_q[CTRL_SHIFT_LSB +: CTRL_SHIFT_W];
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: p_d = P_HDR;
      endcase
    end else if (p_q != P_HDR && tmo_q == LIMIT) begin
      err_d = 1'b1;
      p_d   = P_HDR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      p_q     <= P_HDR;
      ta_q    <= '0;
      tb_q    <= '0;
      tc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      sh_q    <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      p_q     <= p_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      tc_q    <= tc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      sh_q    <= sh_d;
      load_q  <= load_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign reg_a     = a_q;
  assign reg_b     = b_q;
  assign sel       = sel_q;
  assign shift     = sh_q;
  assign load      = load_q;
  assign frame_err = err_q;
  assign busy      = (p_q != P_HDR) || rx_active;
endmodule

// File: tb/tb_alu_cmd_rx.sv
// Bench for alu_cmd_rx: directed frames plus randomized frames
// scored against a byte-level frame model.
module tb_alu_cmd_rx;
  localparam int CPB = 10;
  localparam int LIMIT = 320;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] reg_a, reg_b;
  logic [2:0] sel;
  logic [3:0] shift;
  logic load, frame_err, busy;

  int checks = 0;
  int fails = 0;
  int loads_seen = 0;
  int errs_seen = 0;

  logic [7:0] m_a, m_b;
  logic [2:0] m_sel;
  logic [3:0] m_shift;
  int m_loads = 0;
  int m_errs = 0;
  bit m_in = 0;
  logic [7:0] m_frm[$];

  always #5 clk = ~clk;

  alu_cmd_rx #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .reg_a(reg_a), .reg_b(reg_b), .sel(sel), .shift(shift),
    .load(load), .frame_err(frame_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (load) loads_seen++;
    if (frame_err) errs_seen++;
    if (load || frame_err) begin
      checks++;
      if (load && frame_err) begin
        fails++;
        $display("FAIL excl: load=%b frame_err=%b, required not both", load, frame_err);
      end
    end
  end

  task automatic m_reset();
    m_a = 0; m_b = 0; m_sel = 0; m_shift = 0;
    m_in = 0;
    m_frm.delete();
  endtask

  task automatic m_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_errs++;
      m_in = 0;
      m_frm.delete();
    end else if (!m_in) begin
      m_in = (b == 8'hA5);
    end else begin
      m_frm.push_back(b);
      if (m_frm.size() == 4) begin
        if (m_frm[3] == (m_frm[0] ^ m_frm[1] ^ m_frm[2]) && !m_frm[2][7]) begin
          m_a = m_frm[0];
          m_b = m_frm[1];
          m_sel = m_frm[2][2:0];
          m_shift = m_frm[2][6:3];
          m_loads++;
        end else begin
          m_errs++;
        end
        m_frm.delete();
        m_in = 0;
      end
    end
  endtask

  task automatic m_idle(input int n);
    if (m_in && n > LIMIT) begin
      m_errs++;
      m_in = 0;
      m_frm.delete();
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic tx(input logic [7:0] b, input bit ok, input int gap);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(ok, CPB);
    drive(1'b1, gap);
    m_byte(b, ok);
    m_idle(gap);
  endtask

  task automatic send(input logic [7:0] bs[$], input int gap);
    foreach (bs[i]) tx(bs[i], 1'b1, gap);
    drive(1'b1, 5);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== 23'd0) begin
      fails++;
      $display("FAIL reset_regs: got %h required 0", {reg_a, reg_b, sel, shift});
    end
    checks++;
    if ({load, frame_err, busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes: got %b required 000", {load, frame_err, busy});
    end
    rst = 1'b0;
    m_reset();
    drive(1'b1, 20);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_valid_frame();
    logic [7:0] bs[$];
    int l0 = loads_seen;
    bs = '{8'hA5, 8'h12, 8'h34, 8'h1B, 8'h3D};
    send(bs, 3);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h12, 8'h34, 3'd3, 4'd3}) begin
      fails++;
      $display("FAIL valid_regs: got %h %h %0d %0d required 12 34 3 3", reg_a, reg_b, sel, shift);
    end
    checks++;
    if (loads_seen - l0 !== 1) begin
      fails++;
      $display("FAIL valid_load: got %0d pulses required 1", loads_seen - l0);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] bs[$];
    int l0 = loads_seen;
    int e0 = errs_seen;
    bs = '{8'hA5, 8'h12, 8'h34, 8'h1B, 8'h00};
    send(bs, 0);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h12, 8'h34, 3'd3, 4'd3}) begin
      fails++;
      $display("FAIL badchk_hold: got %h %h %0d %0d required 12 34 3 3", reg_a, reg_b, sel, shift);
    end
    checks++;
    if ({loads_seen - l0, errs_seen - e0} !== {32'd0, 32'd1}) begin
      fails++;
      $display("FAIL badchk_pulses: got load=%0d err=%0d required 0 1", loads_seen - l0, errs_seen - e0);
    end
  endtask

  task automatic test_junk();
    logic [7:0] bs[$];
    int e0 = errs_seen;
    bs = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02, 8'h05, 8'h06};
    send(bs, 7);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h01, 8'h02, 3'd5, 4'd0}) begin
      fails++;
      $display("FAIL junk_regs: got %h %h %0d %0d required 01 02 5 0", reg_a, reg_b, sel, shift);
    end
    checks++;
    if (errs_seen - e0 !== 0) begin
      fails++;
      $display("FAIL junk_err: got %0d pulses required 0", errs_seen - e0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] bs[$];
    int e0 = errs_seen;
    tx(8'hA5, 1'b1, 2);
    tx(8'h01, 1'b1, 50);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL tmo_busy_mid: got %b required 1", busy);
    end
    drive(1'b1, 350);
    m_idle(400);
    checks++;
    if ({busy, 32'(errs_seen - e0)} !== {1'b0, 32'd1}) begin
      fails++;
      $display("FAIL tmo_err: got busy=%b err=%0d required 0 1", busy, errs_seen - e0);
    end
    bs = '{8'hA5, 8'h0A, 8'h0B, 8'h01, 8'h00};
    send(bs, 1);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h0A, 8'h0B, 3'd1, 4'd0}) begin
      fails++;
      $display("FAIL tmo_reload: got %h %h %0d %0d required 0a 0b 1 0", reg_a, reg_b, sel, shift);
    end
  endtask

  task automatic test_errors();
    logic [7:0] bs[$];
    int l0 = loads_seen;
    int e0 = errs_seen;
    drive(1'b0, 3);
    drive(1'b1, 30);
    checks++;
    if ({busy, 32'(errs_seen - e0), 32'(loads_seen - l0)} !== 65'd0) begin
      fails++;
      $display("FAIL glitch: got busy=%b err=%0d load=%0d required 0 0 0", busy, errs_seen - e0, loads_seen - l0);
    end
    tx(8'h55, 1'b0, 20);
    checks++;
    if (errs_seen - e0 !== 1) begin
      fails++;
      $display("FAIL stop_err: got %0d pulses required 1", errs_seen - e0);
    end
    bs = '{8'hA5, 8'h01, 8'h02, 8'h80, 8'h83};
    send(bs, 4);
    checks++;
    if ({32'(errs_seen - e0), 32'(loads_seen - l0)} !== {32'd2, 32'd0}) begin
      fails++;
      $display("FAIL ctrl7: got err=%0d load=%0d required 2 0", errs_seen - e0, loads_seen - l0);
    end
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h0A, 8'h0B, 3'd1, 4'd0}) begin
      fails++;
      $display("FAIL ctrl7_hold: got %h %h %0d %0d required 0a 0b 1 0", reg_a, reg_b, sel, shift);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bs[$];
    tx(8'hA5, 1'b1, 2);
    tx(8'h12, 1'b1, 2);
    drive(1'b0, CPB);
    drive(1'b1, 3 * CPB);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_a, reg_b, sel, shift, load, frame_err, busy} !== 26'd0) begin
      fails++;
      $display("FAIL rst_mid: got %h required 0", {reg_a, reg_b, sel, shift, load, frame_err, busy});
    end
    rst = 1'b0;
    m_reset();
    drive(1'b1, 20);
    bs = '{8'hA5, 8'h77, 8'h88, 8'h2A, 8'h77 ^ 8'h88 ^ 8'h2A};
    send(bs, 2);
    checks++;
    if ({reg_a, reg_b, sel, shift} !== {8'h77, 8'h88, 3'd2, 4'd5}) begin
      fails++;
      $display("FAIL rst_reload: got %h %h %0d %0d required 77 88 2 5", reg_a, reg_b, sel, shift);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [7:0] a, b, c, k;
      int kind, bad;
      logic [7:0] fr[5];
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        tx(junk, ($urandom_range(0, 5) != 0), $urandom_range(0, 30));
      end
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom_range(0, 127));
      kind = $urandom_range(0, 5);
      if (kind == 1) c[7] = 1'b1;
      k = a ^ b ^ c;
      if (kind == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
      bad = (kind == 2) ? $urandom_range(0, 4) : -1;
      fr = '{8'hA5, a, b, c, k};
      for (int j = 0; j < 5; j++) tx(fr[j], (j != bad), $urandom_range(0, 30));
      drive(1'b1, 5);
      checks++;
      if ({reg_a, reg_b, sel, shift} !== {m_a, m_b, m_sel, m_shift}) begin
        fails++;
        $display("FAIL rand_regs[%0d]: got %h %h %0d %0d required %h %h %0d %0d",
                 it, reg_a, reg_b, sel, shift, m_a, m_b, m_sel, m_shift);
      end
      checks++;
      if ({loads_seen, errs_seen} !== {m_loads, m_errs}) begin
        fails++;
        $display("FAIL rand_pulses[%0d]: got load=%0d err=%0d required %0d %0d",
                 it, loads_seen, errs_seen, m_loads, m_errs);
      end
      checks++;
      if (busy !== m_in) begin
        fails++;
        $display("FAIL rand_busy[%0d]: got %b required %b", it, busy, m_in);
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_chk();
    test_junk();
    test_timeout();
    test_errors();
    test_reset_midframe();
    m_loads = loads_seen;
    m_errs = errs_seen;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
